tcm_mem_dual: RTL and testbench
===============================

Name: tcm_mem_dual

Overview:
- 128 KiB tightly-coupled memory serving the CPU core's instruction-fetch port and data port, one port each.
- Instruction side returns a 64-bit fetch group (two 32-bit instructions) per request.
- Data side performs 32-bit reads/writes with byte enables and echoes a request tag.
- Sits beside the core in the simulation top; it is preloaded by a byte-wise backdoor task before the core leaves reset.

Parameters:
- RAM_ADDR_W, 14, 64-bit word index width (2^14 words x 8 bytes = 128 KiB).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_i_rd_i  in  1  instruction fetch request
mem_i_flush_i  in  1  fetch-side flush hint (ignored)
mem_i_invalidate_i  in  1  fetch-side invalidate hint (ignored)
mem_i_pc_i  in  32  fetch byte address
mem_i_accept_o  out  1  fetch request accepted
mem_i_valid_o  out  1  fetch data valid
mem_i_error_o  out  1  fetch error
mem_i_inst_o  out  64  fetched 64-bit word
mem_d_addr_i  in  32  data byte address
mem_d_data_wr_i  in  32  write data
mem_d_rd_i  in  1  read request
mem_d_wr_i  in  4  byte write enables (non-zero = write)
mem_d_cacheable_i  in  1  ignored
mem_d_req_tag_i  in  11  request tag
mem_d_invalidate_i  in  1  cache-maintenance request
mem_d_writeback_i  in  1  cache-maintenance request
mem_d_flush_i  in  1  cache-maintenance request
mem_d_data_rd_o  out  32  read data
mem_d_accept_o  out  1  data request accepted
mem_d_ack_o  out  1  data response valid
mem_d_error_o  out  1  data error
mem_d_resp_tag_o  out  11  echoed tag

Behaviour:
- Storage: internal instance u_ram holding array ram[0:2^RAM_ADDR_W-1] of 64-bit words. Word index = addr[16:3]; addr[31:17] are ignored, so 0x80009000 maps to word 0x1200. Little-endian: byte k of a word is bits [8k+7:8k].
- Backdoor task write(addr, data8): writes one byte at byte offset addr[16:0] with zero delay. It is used before reset release.
- Reset (synchronous, rst_i high at clk edge): mem_i_valid_o=0, mem_d_ack_o=0, mem_d_resp_tag_o=0. RAM contents are not cleared.
- Error outputs are constant 0. mem_i_accept_o and mem_d_accept_o are constant 1, so the block never stalls.
- Fetch port:
  - On a cycle with mem_i_rd_i=1, the next cycle has mem_i_valid_o=1 and mem_i_inst_o=ram[pc[16:3]]. pc[2:0] is ignored.
  - mem_i_valid_o=0 after a cycle without a request.
  - Back-to-back requests give back-to-back valids, one per cycle, in order.
  - mem_i_inst_o holds its last value when not valid.
- Data read: with rd_i=1, the next cycle has ack=1 and data_rd_o = addr[2] ? word[63:32] : word[31:0].
- Data write: with wr_i!=0, byte lanes are updated at the clock edge.
  - addr[2]=0: wr_i[k] enables byte k.
  - addr[2]=1: wr_i[k] enables byte k+4, taking data_wr_i[8k+7:8k].
  - ack=1 the next cycle; data_rd_o is don't-care on a write ack.
- invalidate/writeback/flush requests: no storage effect, ack=1 the next cycle.
- resp_tag_o = the req_tag_i registered on every accepted request. Ack and tag share one-cycle latency; one outstanding response per cycle.
- Simultaneous rd and wr on the data port: the write is performed and the read returns pre-write data.
- Fetch and data port hitting the same word in the same cycle: the fetch returns pre-write data.
- Reset mid-operation: a pending valid/ack is dropped (0 the next cycle); RAM keeps its contents.
- mem_d_addr_i is byte-addressed; misaligned word accesses are not supported (addr[1:0] are ignored).

Test Plan:
- Backdoor write bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 at offsets 0..7, fetch pc=0x80000000 -> 1 cycle later valid=1, inst=0x0010009300000013.
- Data write 0xC0DE000D, wr=0xF, addr=0x80009000, tag=0x055 -> ack=1 next cycle with tag 0x055. Read the same address -> data_rd=0xC0DE000D, and ram[0x1200][31:0]=0xC0DE000D.
- Write 0xAAAAAAAA with wr=0xF at 0x80009004, then 0x000055FF with wr=0x2 at the same address, then read -> 0xAAAA55AA; ram[0x1200][63:32]=0xAAAA55AA.
- Fetch every cycle for 8 cycles at pc=0x80000000+8n -> 8 consecutive valids with matching words, no gaps.
- Assert rst_i for 1 cycle while a read is in flight -> ack=0 and resp_tag=0 the next cycle; re-read returns the unchanged data.
- Pulse mem_d_flush_i with tag 0x7FF -> ack=1 and resp_tag=0x7FF next cycle; memory unchanged.

Source files
------------

// File: rtl/tcm_mem_dual.sv
// Dual-port 128 KiB TCM: fetch port returns a 64-bit group, data port does 32-bit byte-enabled access.
// One-cycle read/ack latency on both ports; accepts every cycle and never applies backpressure.
module tcm_mem_dual_ram #(
    parameter int AW = 14
) (
    input  logic          i_clk,
    input  logic          i_a_en,
    input  logic [AW-1:0] i_a_addr,
    output logic [63:0]   o_a_dat,
    input  logic          i_b_en,
    input  logic [7:0]    i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [63:0]   i_b_wdat,
    output logic [63:0]   o_b_dat
);
    logic [63:0] ram [0:(2**AW)-1];
    logic [63:0] r_a_dat;
    logic [63:0] r_b_dat;

    // Plain always so the byte backdoor below can also schedule updates to the array.
    always @(posedge i_clk) begin
        for (int k = 0; k < 8; k++) begin
            if (i_b_we[k]) begin
                ram[i_b_addr][8*k +: 8] <= i_b_wdat[8*k +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (i_a_en) begin
            r_a_dat <= ram[i_a_addr];
        end
        if (i_b_en) begin
            r_b_dat <= ram[i_b_addr];
        end
    end

    assign o_a_dat = r_a_dat;
    assign o_b_dat = r_b_dat;

    task write(input logic [AW+2:0] addr, input logic [7:0] data8);
        ram[addr[AW+2:3]][8*addr[2:0] +: 8] <= data8;
    endtask
endmodule

module tcm_mem_dual #(
    parameter int RAM_ADDR_W = 14
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [63:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);
    logic        w_d_req;
    logic [7:0]  w_d_be;
    logic [63:0] w_d_wdat;
    logic [63:0] w_b_dat;
    logic        w_unused_ok;
    logic        r_i_valid;
    logic        r_d_ack;
    logic [10:0] r_d_tag;
    logic        r_d_hi;

    assign w_d_req  = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i
                    | mem_d_writeback_i | mem_d_flush_i;
    assign w_d_be   = mem_d_addr_i[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
    assign w_d_wdat = {mem_d_data_wr_i, mem_d_data_wr_i};

    tcm_mem_dual_ram #(.AW(RAM_ADDR_W)) u_ram (
        .i_clk    (clk_i),
        .i_a_en   (mem_i_rd_i),
        .i_a_addr (mem_i_pc_i[RAM_ADDR_W+2:3]),
        .o_a_dat  (mem_i_inst_o),
        .i_b_en   (mem_d_rd_i),
        .i_b_we   (w_d_be),
        .i_b_addr (mem_d_addr_i[RAM_ADDR_W+2:3]),
        .i_b_wdat (w_d_wdat),
        .o_b_dat  (w_b_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_i_valid <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_tag   <= 11'd0;
            r_d_hi    <= 1'b0;
        end else begin
            r_i_valid <= mem_i_rd_i;
            r_d_ack   <= w_d_req;
            if (w_d_req) begin
                r_d_tag <= mem_d_req_tag_i;
            end
            if (mem_d_rd_i) begin
                r_d_hi <= mem_d_addr_i[2];
            end
        end
    end

    assign mem_i_accept_o   = 1'b1;
    assign mem_i_error_o    = 1'b0;
    assign mem_i_valid_o    = r_i_valid;
    assign mem_d_accept_o   = 1'b1;
    assign mem_d_error_o    = 1'b0;
    assign mem_d_ack_o      = r_d_ack;
    assign mem_d_resp_tag_o = r_d_tag;
    assign mem_d_data_rd_o  = r_d_hi ? w_b_dat[63:32] : w_b_dat[31:0];

    assign w_unused_ok = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
                           mem_d_cacheable_i, mem_d_addr_i};
endmodule

// File: tb/tb_tcm_mem_dual.sv
// Directed stimulus with expected responses queued at issue time and popped by a negedge monitor.
module tb_tcm_mem_dual;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [63:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    tcm_mem_dual dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
        .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
        .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
        .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
        .mem_d_flush_i(mem_d_flush_i), .mem_d_data_rd_o(mem_d_data_rd_o),
        .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
        .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        chk;
        logic [31:0] dat;
        logic [10:0] tag;
    } dexp_t;

    logic [63:0] q_i[$];
    dexp_t       q_d[$];
    logic [63:0] e_i;
    dexp_t       e_d;
    int          errors = 0;
    int          checks = 0;
    int          n_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever a fetch valid or data ack is presented.
    always @(negedge clk_i) begin
        if (mem_i_valid_o) begin
            n_valid++;
            checks++;
            if (q_i.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected: got valid inst %h expected no valid", mem_i_inst_o);
            end else begin
                e_i = q_i.pop_front();
                if (mem_i_inst_o !== e_i) begin
                    errors++;
                    $display("FAIL fetch_inst: got %h expected %h", mem_i_inst_o, e_i);
                end
            end
        end
        if (mem_d_ack_o) begin
            checks++;
            if (q_d.size() == 0) begin
                errors++;
                $display("FAIL data_unexpected: got ack tag %h expected no ack", mem_d_resp_tag_o);
            end else begin
                e_d = q_d.pop_front();
                if (mem_d_resp_tag_o !== e_d.tag) begin
                    errors++;
                    $display("FAIL data_tag: got %h expected %h", mem_d_resp_tag_o, e_d.tag);
                end
                if (e_d.chk) begin
                    checks++;
                    if (mem_d_data_rd_o !== e_d.dat) begin
                        errors++;
                        $display("FAIL data_rd tag %h: got %h expected %h",
                                 e_d.tag, mem_d_data_rd_o, e_d.dat);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_req();
        mem_i_rd_i = 1'b0; mem_i_pc_i = '0;
        mem_d_rd_i = 1'b0; mem_d_wr_i = '0; mem_d_addr_i = '0; mem_d_data_wr_i = '0;
        mem_d_req_tag_i = '0; mem_d_invalidate_i = 1'b0; mem_d_writeback_i = 1'b0;
        mem_d_flush_i = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [63:0] exp);
        mem_i_rd_i = 1'b1; mem_i_pc_i = pc;
        q_i.push_back(exp);
    endtask

    task automatic dreq(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [10:0] tag, input logic [31:0] exp);
        dexp_t e;
        mem_d_rd_i = rd; mem_d_wr_i = wr; mem_d_addr_i = addr;
        mem_d_data_wr_i = wdat; mem_d_req_tag_i = tag;
        e.chk = rd; e.dat = exp; e.tag = tag;
        q_d.push_back(e);
    endtask

    function automatic logic [63:0] fw(input int n);
        return (n == 0) ? 64'h0010009300000013 : {32'hCAFE0000 + 32'(n), 32'h00000100 + 32'(n)};
    endfunction

    initial begin
        logic [63:0] w;
        int base;
        rst_i = 1'b1;
        mem_i_flush_i = 1'b0; mem_i_invalidate_i = 1'b0; mem_d_cacheable_i = 1'b1;
        clear_req();
        for (int n = 0; n < 8; n++) begin
            w = fw(n);
            for (int k = 0; k < 8; k++) dut.u_ram.write(17'(8*n + k), w[8*k +: 8]);
        end
        tick(); tick();
        #4;
        chk("reset_valid", 64'(mem_i_valid_o), 64'd0);
        chk("reset_ack", 64'(mem_d_ack_o), 64'd0);
        chk("reset_tag", 64'(mem_d_resp_tag_o), 64'd0);
        chk("accept_err", {60'd0, mem_i_accept_o, mem_d_accept_o, mem_i_error_o, mem_d_error_o},
            64'b1100);
        tick();
        rst_i = 1'b0;

        fetch(32'h80000000, 64'h0010009300000013); tick(); clear_req();
        dreq(1'b0, 4'hF, 32'h80009000, 32'hC0DE000D, 11'h055, 32'h0); tick();
        dreq(1'b1, 4'h0, 32'h80009000, 32'h0, 11'h056, 32'hC0DE000D); tick(); clear_req();
        tick();
        chk("ram_1200_lo", 64'(dut.u_ram.ram[14'h1200][31:0]), 64'hC0DE000D);

        dreq(1'b0, 4'hF, 32'h80009004, 32'hAAAAAAAA, 11'h001, 32'h0); tick();
        dreq(1'b0, 4'h2, 32'h80009004, 32'h000055FF, 11'h002, 32'h0); tick();
        dreq(1'b1, 4'h0, 32'h80009004, 32'h0, 11'h003, 32'hAAAA55AA); tick(); clear_req();
        tick();
        chk("ram_1200_hi", 64'(dut.u_ram.ram[14'h1200][63:32]), 64'hAAAA55AA);

        base = n_valid;
        for (int n = 0; n < 8; n++) begin
            fetch(32'h80000000 + 32'(8*n), fw(n)); tick();
        end
        clear_req();
        @(posedge clk_i); #6;
        chk("fetch_b2b_count", 64'(n_valid - base), 64'd8);
        chk("fetch_idle_valid", 64'(mem_i_valid_o), 64'd0);
        chk("inst_hold", mem_i_inst_o, fw(7));

        // Same-cycle fetch, read and write to one word: both reads see the old contents.
        fetch(32'h80009000, 64'hAAAA55AAC0DE000D);
        dreq(1'b1, 4'hF, 32'h80009000, 32'h12345678, 11'h010, 32'hC0DE000D); tick(); clear_req();
        dreq(1'b1, 4'h0, 32'h80009000, 32'h0, 11'h011, 32'h12345678); tick(); clear_req();
        tick();

        mem_d_rd_i = 1'b1; mem_d_addr_i = 32'h80009004; mem_d_req_tag_i = 11'h123; rst_i = 1'b1;
        tick(); clear_req(); rst_i = 1'b0;
        #4;
        chk("rst_drop_ack", 64'(mem_d_ack_o), 64'd0);
        chk("rst_drop_tag", 64'(mem_d_resp_tag_o), 64'd0);
        tick();
        dreq(1'b1, 4'h0, 32'h80009004, 32'h0, 11'h124, 32'hAAAA55AA); tick(); clear_req();

        dreq(1'b0, 4'h0, 32'h80009000, 32'h0, 11'h7FF, 32'h0); mem_d_flush_i = 1'b1;
        tick(); clear_req();
        dreq(1'b1, 4'h0, 32'h80009000, 32'h0, 11'h200, 32'h12345678); tick(); clear_req();
        tick(); tick();
        chk("ram_after_flush", dut.u_ram.ram[14'h1200], 64'hAAAA55AA12345678);
        chk("fetch_q_drained", 64'(q_i.size()), 64'd0);
        chk("data_q_drained", 64'(q_d.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
